rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered multi-cycle writes (power of two, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive cycles a buffered write may wait before a stall is requested.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-low reset; asserted when 0.
REQ-006 SHALL have ports p_valid in 1, p_rd in 5, p_wd in 32: pipeline writeback request; no backpressure.
REQ-007 SHALL have ports m_valid in 1, m_ready out 1, m_rd in 5, m_wd in 32: multi-cycle unit result, valid/ready handshake.
REQ-008 SHALL have ports rf_wr out 1, rf_a3 out 5, rf_wd out 32: the single register-file write port.
REQ-009 SHALL have ports q1 in 5, q2 in 5, hit1 out 1, hit2 out 1: pending-write query, for the hazard unit.
REQ-010 SHALL have port stall_o out 1: request to the pipeline to insert a writeback bubble.

Function
REQ-011 SHALL accept an m beat when m_valid&&m_ready; m_ready = (count<DEPTH), from registered state only.
REQ-012 SHALL grant the port per cycle in this priority: (a) p_valid&&p_rd!=0; (b) FIFO head, which is popped; (c) same-cycle accepted m beat with FIFO empty (bypass, zero latency).
REQ-013 SHALL push an accepted m beat into the FIFO tail when it is not bypassed; push and pop in one cycle leave count unchanged.
REQ-014 SHALL drive rf_wr/rf_a3/rf_wd combinationally from the granted source; rf_wr=0 with rf_a3=0, rf_wd=0 when there is no grant.
REQ-015 SHALL never assert rf_wr with rf_a3=0; m beats with m_rd=0 are accepted and discarded (no push).
REQ-016 SHALL apply the WAW rule: on a granted p write to rd X, invalidate every FIFO entry and any same-cycle accepted m beat with rd X; invalidated entries are skipped (popped without a write) and do not count as pending.
REQ-017 SHALL keep FIFO order; read and write pointers wrap modulo DEPTH.
REQ-018 SHALL assert hitN = 1 iff qN!=0 and a valid FIFO entry has rd==qN (combinational, excluding the current-cycle bypass).
REQ-019 SHALL keep starve counter sc: sc+1 (saturating at STARVE_MAX) each cycle FIFO holds a valid entry and no pop occurs; 0 on any pop or when empty.
REQ-020 SHALL register stall_o: set the cycle after sc reaches STARVE_MAX; clear the cycle after the next FIFO pop.
REQ-021 SHALL, while stall_o=1, require p_valid=0 (pipeline contract); the head then wins per REQ-012(b).
REQ-022 SHALL, if p_valid=1 arrives while stall_o=1, still grant p (no data loss); the bench flags it as a contract violation.

Reset
REQ-023 SHALL, on clk edge with rst=0, clear the pointers, count, valid bits, sc and stall_o; m_ready=0 and rf_wr=0 during reset; m_ready=1 the first cycle after release.
REQ-024 SHALL discard in-flight FIFO contents on reset mid-operation; no rf_wr in the reset cycle.

Structure
REQ-025 SHALL place the constants REG_W=5, XLEN=32 and the default DEPTH/STARVE_MAX in the shared cpu package.
REQ-026 SHALL implement the buffer as one sub-module rf_wr_fifo (push/pop/per-entry invalidate/CAM match); the arbitration, starve counter and stall in the top level.
REQ-027 SHALL total 120-400 RTL lines; no latches, and no combinational path from m_valid to m_ready.

Verification
REQ-028 SHALL cover: idle, m_valid=1 m_rd=5 m_wd=0xAA -> same cycle rf_wr=1, rf_a3=5, rf_wd=0xAA (bypass).
REQ-029 SHALL cover: p_valid=1 rd=3 and m_valid=1 rd=7 in the same cycle -> rd 3 written; rd 7 written next cycle; hit on q1=7 for exactly one cycle.
REQ-030 SHALL cover: p_valid held 1 (rd 1-4) while 2 m beats arrive -> m_ready=0 after 2 pushes; stall_o=1 after STARVE_MAX waiting cycles; once p_valid drops, heads written in order; stall_o clears.
REQ-031 SHALL cover: FIFO holds rd 9 = 0x11, then p write rd 9 = 0x22 -> final value 0x22; no later write to rd 9; hit1(q1=9)=0 after the p write.
REQ-032 SHALL cover: m beat with m_rd=0 -> accepted, rf_wr=0, count unchanged.
REQ-033 SHALL cover: rst=0 with 2 entries buffered -> next cycle count=0, stall_o=0, m_ready=0; after release, no stale write occurs.

Source files
------------

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared CPU constants and types for the register-file write arbiter.
package rf_wr_arbiter_pkg;

    localparam int REG_W              = 5;
    localparam int XLEN               = 32;
    localparam int DEFAULT_DEPTH      = 2;
    localparam int DEFAULT_STARVE_MAX = 4;

    // Which requester owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_HEAD,
        SRC_BYPASS
    } wr_src_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Buffer of pending multi-cycle writes with per-entry invalidate and rd match.
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [REG_W-1:0]       push_rd,
    input  logic [XLEN-1:0]        push_wd,
    input  logic                   pop,
    input  logic                   inv_en,
    input  logic [REG_W-1:0]       inv_rd,
    input  logic [REG_W-1:0]       q1,
    input  logic [REG_W-1:0]       q2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   head_valid,
    output logic [REG_W-1:0]       head_rd,
    output logic [XLEN-1:0]        head_wd,
    output logic                   any_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [REG_W-1:0] rd_mem [DEPTH];
    logic [XLEN-1:0]  wd_mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp;
    logic [PW:0]      cnt;

    // Pointers, occupancy and valid bits; invalidation first, then pop/push
    always_ff @(posedge clk) begin
        if (!rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inv_en && (rd_mem[i] == inv_rd)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
            end
            if (push) begin
                vld[wp] <= 1'b1;
                wp      <= wp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage, only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wp] <= push_rd;
            wd_mem[wp] <= push_wd;
        end
    end

    // Pending-write lookup for the hazard unit over still-valid entries
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (rd_mem[i] == q1)) hit1 = 1'b1;
            if (vld[i] && (rd_mem[i] == q2)) hit2 = 1'b1;
        end
        if (q1 == '0) hit1 = 1'b0;
        if (q2 == '0) hit2 = 1'b0;
    end

    assign count      = cnt;
    assign empty      = (cnt == '0);
    assign head_valid = !empty && vld[rp];
    assign head_rd    = rd_mem[rp];
    assign head_wd    = wd_mem[rp];
    assign any_valid  = |vld;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and
// buffered multi-cycle results, with starvation detection and a stall request.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic [REG_W-1:0] p_rd,
    input  logic [XLEN-1:0]  p_wd,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [REG_W-1:0] m_rd,
    input  logic [XLEN-1:0]  m_wd,
    output logic             rf_wr,
    output logic [REG_W-1:0] rf_a3,
    output logic [XLEN-1:0]  rf_wd,
    input  logic [REG_W-1:0] q1,
    input  logic [REG_W-1:0] q2,
    output logic             hit1,
    output logic             hit2,
    output logic             stall_o
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             SW       = $clog2(STARVE_MAX + 1);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [SW-1:0]  SC_MAX   = SW'(STARVE_MAX);

    logic [PW:0]      count;
    logic             empty;
    logic             head_valid;
    logic [REG_W-1:0] head_rd;
    logic [XLEN-1:0]  head_wd;
    logic             any_valid;
    logic             accept;
    logic             push;
    logic             pop;
    logic             inv_en;
    wr_src_e          src;
    logic [SW-1:0]    sc;
    logic             stall_q;

    // Ready depends only on registered occupancy and reset, never on m_valid
    assign m_ready = rst && (count < FULL_CNT);
    assign accept  = m_valid && m_ready;
    assign inv_en  = (src == SRC_PIPE);
    assign stall_o = stall_q;

    rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_rd    (m_rd),
        .push_wd    (m_wd),
        .pop        (pop),
        .inv_en     (inv_en),
        .inv_rd     (p_rd),
        .q1         (q1),
        .q2         (q2),
        .hit1       (hit1),
        .hit2       (hit2),
        .count      (count),
        .empty      (empty),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_wd    (head_wd),
        .any_valid  (any_valid)
    );

    // Grant selection, FIFO push/pop and the write-port mux; an invalidated
    // head is dropped in the same cycle regardless of who owns the port
    always_comb begin
        src   = SRC_NONE;
        pop   = 1'b0;
        push  = 1'b0;
        rf_wr = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (rst) begin
            if (p_valid && (p_rd != '0)) begin
                src = SRC_PIPE;
            end else if (head_valid) begin
                src = SRC_HEAD;
            end else if (accept && empty && (m_rd != '0)) begin
                src = SRC_BYPASS;
            end
            pop  = (!empty && !head_valid) || (src == SRC_HEAD);
            push = accept && (m_rd != '0) && (src != SRC_BYPASS) &&
                   !((src == SRC_PIPE) && (m_rd == p_rd));
            case (src)
                SRC_PIPE: begin
                    rf_wr = 1'b1;
                    rf_a3 = p_rd;
                    rf_wd = p_wd;
                end
                SRC_HEAD: begin
                    rf_wr = 1'b1;
                    rf_a3 = head_rd;
                    rf_wd = head_wd;
                end
                SRC_BYPASS: begin
                    rf_wr = 1'b1;
                    rf_a3 = m_rd;
                    rf_wd = m_wd;
                end
                default: begin
                    rf_wr = 1'b0;
                end
            endcase
        end
    end

    // Starve counter and registered stall request, both released by any pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            sc      <= '0;
            stall_q <= 1'b0;
        end else begin
            if (pop || !any_valid) begin
                sc <= '0;
            end else if (sc != SC_MAX) begin
                sc <= sc + 1'b1;
            end
            if (pop) begin
                stall_q <= 1'b0;
            end else if (sc == SC_MAX) begin
                stall_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_wd;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        hit1;
    logic        hit2;
    logic        stall_o;

    int checks = 0;
    int passes = 0;

    rf_wr_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_rd    (p_rd),
        .p_wd    (p_wd),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rd    (m_rd),
        .m_wd    (m_wd),
        .rf_wr   (rf_wr),
        .rf_a3   (rf_a3),
        .rf_wd   (rf_wd),
        .q1      (q1),
        .q2      (q2),
        .hit1    (hit1),
        .hit2    (hit2),
        .stall_o (stall_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst && p_valid && stall_o) begin
            $display("[TB] contract violation: p_valid asserted while stall_o=1");
        end
    end

    task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pwd,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                                 input logic [4:0] qa, input logic [4:0] qb);
        p_valid = pv;
        p_rd    = prd;
        p_wd    = pwd;
        m_valid = mv;
        m_rd    = mrd;
        m_wd    = mwd;
        q1      = qa;
        q2      = qb;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_m_ready", m_ready, 0);
        checkOutput("rst_rf_wr", rf_wr, 0);
        checkOutput("rst_stall", stall_o, 0);
        rst = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rel_m_ready", m_ready, 1);
        checkOutput("rel_rf_wr", rf_wr, 0);

        // Zero-latency bypass of an m beat into an idle port
        applyStimulus(0, 0, 0, 1, 5, 32'hAA, 5, 0);
        checkOutput("byp_wr", rf_wr, 1);
        checkOutput("byp_a3", rf_a3, 5);
        checkOutput("byp_wd", rf_wd, 32'hAA);
        checkOutput("byp_hit1", hit1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("byp_after_wr", rf_wr, 0);
        checkOutput("byp_after_a3", rf_a3, 0);
        checkOutput("byp_after_hit1", hit1, 0);
        nextCycle();

        // Pipeline wins; m beat buffered one cycle and visible to the query
        applyStimulus(1, 3, 32'h33, 1, 7, 32'h77, 7, 0);
        checkOutput("pm_a3", rf_a3, 3);
        checkOutput("pm_wd", rf_wd, 32'h33);
        checkOutput("pm_hit1_pre", hit1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
        checkOutput("pm_head_wr", rf_wr, 1);
        checkOutput("pm_head_a3", rf_a3, 7);
        checkOutput("pm_head_wd", rf_wd, 32'h77);
        checkOutput("pm_hit1", hit1, 1);
        checkOutput("pm_hit2", hit2, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("pm_done_wr", rf_wr, 0);
        checkOutput("pm_done_hit1", hit1, 0);
        nextCycle();

        // Held pipeline traffic fills the FIFO and starves it into a stall
        applyStimulus(1, 1, 32'h101, 1, 10, 32'hA0, 0, 0);
        checkOutput("st_c0_a3", rf_a3, 1);
        nextCycle();
        applyStimulus(1, 2, 32'h102, 1, 11, 32'hB0, 10, 11);
        checkOutput("st_c1_ready", m_ready, 1);
        checkOutput("st_c1_hit1", hit1, 1);
        nextCycle();
        applyStimulus(1, 3, 32'h103, 0, 0, 0, 0, 0);
        checkOutput("st_full_ready", m_ready, 0);
        nextCycle();
        applyStimulus(1, 4, 32'h104, 0, 0, 0, 0, 0);
        checkOutput("st_c3_stall", stall_o, 0);
        nextCycle();
        applyStimulus(1, 1, 32'h105, 0, 0, 0, 0, 0);
        checkOutput("st_c4_a3", rf_a3, 1);
        nextCycle();
        applyStimulus(1, 2, 32'h106, 0, 0, 0, 0, 0);
        checkOutput("st_c5_stall", stall_o, 0);
        checkOutput("st_c5_wd", rf_wd, 32'h106);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_c6_stall", stall_o, 1);
        checkOutput("st_c6_a3", rf_a3, 10);
        checkOutput("st_c6_wd", rf_wd, 32'hA0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_c7_stall", stall_o, 0);
        checkOutput("st_c7_a3", rf_a3, 11);
        checkOutput("st_c7_wd", rf_wd, 32'hB0);
        checkOutput("st_c7_ready", m_ready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_c8_wr", rf_wr, 0);
        nextCycle();

        // WAW: younger pipeline write kills the buffered older one
        applyStimulus(1, 6, 32'h66, 1, 9, 32'h11, 9, 0);
        checkOutput("waw_c0_a3", rf_a3, 6);
        nextCycle();
        applyStimulus(1, 9, 32'h22, 0, 0, 0, 9, 0);
        checkOutput("waw_c1_hit1", hit1, 1);
        checkOutput("waw_c1_a3", rf_a3, 9);
        checkOutput("waw_c1_wd", rf_wd, 32'h22);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("waw_c2_hit1", hit1, 0);
        checkOutput("waw_c2_wr", rf_wr, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("waw_c3_wr", rf_wr, 0);
        checkOutput("waw_c3_ready", m_ready, 1);
        nextCycle();

        // m beat to x0 is accepted and dropped without occupying a slot
        applyStimulus(0, 0, 0, 1, 0, 32'h55, 0, 0);
        checkOutput("x0_ready", m_ready, 1);
        checkOutput("x0_wr", rf_wr, 0);
        nextCycle();
        applyStimulus(1, 1, 32'h201, 1, 12, 32'hC0, 0, 0);
        checkOutput("x0_c1_ready", m_ready, 1);
        nextCycle();
        applyStimulus(1, 2, 32'h202, 1, 13, 32'hD0, 0, 0);
        checkOutput("x0_c2_ready", m_ready, 1);
        nextCycle();

        // Reset with two entries buffered discards them
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 13);
        checkOutput("mr_full_hit1", hit1, 1);
        checkOutput("mr_rf_wr", rf_wr, 0);
        checkOutput("mr_m_ready", m_ready, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 13);
        checkOutput("mr_next_stall", stall_o, 0);
        checkOutput("mr_next_ready", m_ready, 0);
        checkOutput("mr_next_hit1", hit1, 0);
        checkOutput("mr_next_hit2", hit2, 0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 13);
        checkOutput("mr_rel_wr", rf_wr, 0);
        checkOutput("mr_rel_ready", m_ready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mr_rel2_wr", rf_wr, 0);
        checkOutput("mr_rel2_stall", stall_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
